spi_register_bank: RTL and testbench

- System-clock-domain register file that sits directly downstream of the SPI slave interface.
- Consumes the slave's synced received word, its address and write-enable, and its synced new-data flag.
- Returns the word to shift out next (data_to_send) and the clear_new_data_flag handshake.
- Exposes writable control registers to the velocity controller and maps read-only status inputs into the SPI address space.

---
 rtl/spi_register_bank.sv | 157 +++++++++++++++
 tb/tb_spi_register_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_register_bank.sv
// Register bank in the system clock domain behind the SPI slave: control
// registers written by SPI frames, status words readable in the same address map.
module spi_register_bank #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 4,
  parameter int NUM_RW        = 8,
  parameter int NUM_RO        = 4,
  parameter int CLEAR_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cs,
  input  logic [DATA_WIDTH-1:0]        spi_address,
  input  logic                         spi_write_enable,
  input  logic [DATA_WIDTH-1:0]        spi_data,
  input  logic                         new_data_flag,
  output logic                         clear_new_data_flag,
  output logic [DATA_WIDTH-1:0]        data_to_send,
  input  logic [NUM_RO*DATA_WIDTH-1:0] status_in,
  output logic [NUM_RW*DATA_WIDTH-1:0] ctrl_regs,
  output logic                         write_strobe,
  output logic [ADDR_WIDTH-1:0]        write_addr,
  output logic                         error_flag
);

  localparam int CNT_W = $clog2(CLEAR_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] NUM_RW_A = ADDR_WIDTH'(NUM_RW);
  localparam logic [CNT_W-1:0]      TMO_A    = CNT_W'(CLEAR_TIMEOUT);

  typedef enum logic [1:0] {IDLE, CAPTURE, CLEAR_WAIT} state_t;

  state_t                  state_q, state_d;
  logic                    cs_m_q, cs_s_q, we_m_q, we_s_q;
  logic [DATA_WIDTH-1:0]   addr_m_q, addr_s_q;
  logic [DATA_WIDTH-1:0]   ctrl_q [NUM_RW];
  logic [DATA_WIDTH-1:0]   ctrl_d [NUM_RW];
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    first_q, first_d;
  logic                    clear_q, clear_d;
  logic                    strobe_q, strobe_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    unused_addr_hi;

  assign addr           = addr_s_q[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^addr_s_q[DATA_WIDTH-1:ADDR_WIDTH];

  // Two-flop synchronizers for the SPI-domain control and address
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_m_q   <= 1'b0;
      cs_s_q   <= 1'b0;
      we_m_q   <= 1'b0;
      we_s_q   <= 1'b0;
      addr_m_q <= '0;
      addr_s_q <= '0;
    end else begin
      cs_m_q   <= cs;
      cs_s_q   <= cs_m_q;
      we_m_q   <= spi_write_enable;
      we_s_q   <= we_m_q;
      addr_m_q <= spi_address;
      addr_s_q <= addr_m_q;
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NUM_RW; k++)
      if (addr == ADDR_WIDTH'(k)) rd_data_d = ctrl_q[k];
    for (int k = 0; k < NUM_RO; k++)
      if (addr == ADDR_WIDTH'(NUM_RW + k)) rd_data_d = status_in[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    clear_d  = clear_q;
    strobe_d = 1'b0;
    err_d    = err_q;
    waddr_d  = waddr_q;
    first_d  = first_q;
    case (state_q)
      IDLE: begin
        if (new_data_flag) state_d = CAPTURE;
      end
      CAPTURE: begin
        // The first event of a frame is the command byte and is never written
        if (!first_q && we_s_q) begin
          if (addr < NUM_RW_A) begin
            for (int k = 0; k < NUM_RW; k++)
              if (addr == ADDR_WIDTH'(k)) ctrl_d[k] = spi_data;
            strobe_d = 1'b1;
            waddr_d  = addr;
          end else begin
            err_d = 1'b1;
          end
        end
        first_d = 1'b0;
        clear_d = 1'b1;
        cnt_d   = '0;
        state_d = CLEAR_WAIT;
      end
      CLEAR_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!new_data_flag) begin
          clear_d = 1'b0;
          state_d = IDLE;
        end else if (cnt_d == TMO_A) begin
          clear_d = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (cs_s_q) first_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      for (int k = 0; k < NUM_RW; k++) ctrl_q[k] <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      clear_q   <= 1'b0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
      waddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      clear_q   <= clear_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
      waddr_q   <= waddr_d;
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_flat
    assign ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
  end

  assign clear_new_data_flag = clear_q;
  assign data_to_send        = rd_data_q;
  assign write_strobe        = strobe_q;
  assign write_addr          = waddr_q;
  assign error_flag          = err_q;

endmodule

// File: tb/tb_spi_register_bank.sv
// Directed bench for spi_register_bank: write frames, read mux, illegal
// writes, clear timeout and mid-frame reset.
module tb_spi_register_bank;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cs;
  logic [15:0]  spi_address;
  logic         spi_write_enable;
  logic [15:0]  spi_data;
  logic         new_data_flag;
  logic         clear_new_data_flag;
  logic [15:0]  data_to_send;
  logic [63:0]  status_in;
  logic [127:0] ctrl_regs;
  logic         write_strobe;
  logic [3:0]   write_addr;
  logic         error_flag;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int strobe_wide = 0;
  int clr_rise = 0;
  logic prev_strobe = 1'b0;
  logic prev_clear  = 1'b0;
  logic [127:0] exp_ctrl;

  spi_register_bank dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cs                  (cs),
    .spi_address         (spi_address),
    .spi_write_enable    (spi_write_enable),
    .spi_data            (spi_data),
    .new_data_flag       (new_data_flag),
    .clear_new_data_flag (clear_new_data_flag),
    .data_to_send        (data_to_send),
    .status_in           (status_in),
    .ctrl_regs           (ctrl_regs),
    .write_strobe        (write_strobe),
    .write_addr          (write_addr),
    .error_flag          (error_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_strobe) strobe_cnt++;
    if (write_strobe && prev_strobe) strobe_wide++;
    if (clear_new_data_flag && !prev_clear) clr_rise++;
    prev_strobe = write_strobe;
    prev_clear  = clear_new_data_flag;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_event(input logic [15:0] d, input string tag);
    int n;
    int r0;
    r0 = clr_rise;
    spi_data = d;
    new_data_flag = 1'b1;
    n = 0;
    while (!clear_new_data_flag && n < 20) begin tick(1); n++; end
    new_data_flag = 1'b0;
    n = 0;
    while (clear_new_data_flag && n < 20) begin tick(1); n++; end
    tick(1);
    check_eq({tag, "_clr_rise"}, 128'(clr_rise - r0), 128'd1);
    check_eq({tag, "_clr_low"}, 128'(clear_new_data_flag), 128'd0);
  endtask

  task automatic set_addr(input logic [15:0] a, input logic we);
    spi_address = a;
    spi_write_enable = we;
    tick(3);
  endtask

  initial begin
    int n;
    int s0;
    reset_n = 1'b0;
    status_in = {16'hD00D, 16'hC0DE, 16'hA5A5, 16'h0F0F};
    spi_data = '0;
    exp_ctrl = '0;
    for (int i = 0; i < 3; i++) begin
      cs = 1'($urandom);
      spi_address = 16'($urandom);
      spi_write_enable = 1'($urandom);
      new_data_flag = 1'($urandom);
      spi_data = 16'($urandom);
      tick(1);
    end
    cs = 1'b1; spi_address = '0; spi_write_enable = 1'b0; new_data_flag = 1'b0;
    check_eq("rst_ctrl", ctrl_regs, 128'd0);
    check_eq("rst_dts", 128'(data_to_send), 128'd0);
    check_eq("rst_clear", 128'(clear_new_data_flag), 128'd0);
    check_eq("rst_err", 128'(error_flag), 128'd0);
    check_eq("rst_strobe", 128'(write_strobe), 128'd0);
    reset_n = 1'b1;
    tick(3);

    // Write frame: command byte then data to register 2
    cs = 1'b0;
    set_addr(16'd2, 1'b1);
    s0 = strobe_cnt;
    spi_event(16'h1111, "cmd");
    check_eq("cmd_no_strobe", 128'(strobe_cnt - s0), 128'd0);
    check_eq("cmd_no_write", ctrl_regs, exp_ctrl);
    spi_event(16'hBEEF, "wr2");
    exp_ctrl[2*16 +: 16] = 16'hBEEF;
    check_eq("wr2_ctrl", ctrl_regs, exp_ctrl);
    check_eq("wr2_strobe", 128'(strobe_cnt - s0), 128'd1);
    check_eq("wr2_waddr", 128'(write_addr), 128'd2);
    check_eq("wr2_readback", 128'(data_to_send), 128'hBEEF);

    // Read path
    set_addr(16'd5, 1'b1);
    spi_event(16'h1234, "wr5");
    exp_ctrl[5*16 +: 16] = 16'h1234;
    check_eq("wr5_ctrl", ctrl_regs, exp_ctrl);
    check_eq("wr5_waddr", 128'(write_addr), 128'd5);
    set_addr(16'd5, 1'b0);
    check_eq("rd5", 128'(data_to_send), 128'h1234);
    set_addr(16'd9, 1'b0);
    check_eq("rd9", 128'(data_to_send), 128'hA5A5);
    set_addr(16'd14, 1'b0);
    check_eq("rd14", 128'(data_to_send), 128'h0);
    set_addr(16'h0035, 1'b0);
    check_eq("rd_hi_bits", 128'(data_to_send), 128'h1234);
    set_addr(16'd11, 1'b0);
    check_eq("rd11", 128'(data_to_send), 128'hD00D);

    // Illegal write to a read-only address
    set_addr(16'd9, 1'b1);
    s0 = strobe_cnt;
    spi_event(16'hFFFF, "ill");
    check_eq("ill_no_strobe", 128'(strobe_cnt - s0), 128'd0);
    check_eq("ill_ctrl", ctrl_regs, exp_ctrl);
    check_eq("ill_err", 128'(error_flag), 128'd1);
    check_eq("ill_rd9", 128'(data_to_send), 128'hA5A5);
    tick(20);
    check_eq("err_sticky", 128'(error_flag), 128'd1);

    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    exp_ctrl = '0;
    check_eq("rst2_err", 128'(error_flag), 128'd0);
    check_eq("rst2_ctrl", ctrl_regs, exp_ctrl);

    // New frame writing register 1
    cs = 1'b1;
    tick(3);
    cs = 1'b0;
    set_addr(16'd1, 1'b1);
    spi_event(16'h0000, "cmd2");
    spi_event(16'h5A5A, "wr1");
    exp_ctrl[1*16 +: 16] = 16'h5A5A;
    check_eq("wr1_ctrl", ctrl_regs, exp_ctrl);

    // Clear timeout with the flag stuck high
    set_addr(16'd1, 1'b0);
    new_data_flag = 1'b1;
    n = 0;
    while (!clear_new_data_flag && n < 20) begin tick(1); n++; end
    n = 0;
    while (clear_new_data_flag && n < 1000) begin n++; tick(1); end
    check_eq("to_len", 128'(n), 128'd255);
    check_eq("to_err", 128'(error_flag), 128'd1);
    tick(1);
    check_eq("to_capture", 128'(clear_new_data_flag), 128'd0);
    tick(1);
    check_eq("to_reclear", 128'(clear_new_data_flag), 128'd1);

    // Reset while waiting for the flag to drop
    reset_n = 1'b0;
    tick(1);
    check_eq("mid_clear", 128'(clear_new_data_flag), 128'd0);
    check_eq("mid_ctrl", ctrl_regs, 128'd0);
    check_eq("mid_err", 128'(error_flag), 128'd0);
    new_data_flag = 1'b0;
    reset_n = 1'b1;
    exp_ctrl = '0;
    cs = 1'b1;
    tick(3);
    cs = 1'b0;
    set_addr(16'd3, 1'b1);
    s0 = strobe_cnt;
    spi_event(16'h7777, "mid_cmd");
    check_eq("mid_cmd_no_write", ctrl_regs, exp_ctrl);
    check_eq("mid_cmd_no_strobe", 128'(strobe_cnt - s0), 128'd0);
    spi_event(16'h4242, "mid_wr3");
    exp_ctrl[3*16 +: 16] = 16'h4242;
    check_eq("mid_wr3_ctrl", ctrl_regs, exp_ctrl);
    check_eq("mid_wr3_strobe", 128'(strobe_cnt - s0), 128'd1);
    check_eq("mid_wr3_waddr", 128'(write_addr), 128'd3);

    check_eq("strobe_width", 128'(strobe_wide), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
